knn_topk_vote: RTL

Streaming K-nearest selector and majority voter that sits directly downstream of the per-sample distance calculator. For one test query it accepts one (distance, label) pair per cycle from the training-set sweep and keeps the K smallest distances in a sorted register list. After the final sample it counts the binary labels of the retained neighbours and emits the classification for that query.

---
 rtl/knn_topk_vote.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/knn_topk_vote.sv
// knn_topk_vote
//   Streaming K-nearest selector with binary majority vote. Accepts one
//   (distance, label) pair per cycle during COLLECT and keeps the K smallest
//   distances in a sorted register list (entry 0 nearest). After the sample
//   flagged last_i, the retained labels are counted and the classification is
//   presented for one cycle.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   start          : begins a new query (aborts any query in progress)
//   dist_valid     : distance_i / label_i / last_i valid this cycle
//   distance_i     : unsigned distance of the current training sample
//   label_i        : class label of the current training sample
//   last_i         : final training sample of the query
//   in_ready       : samples consumed only when dist_valid && in_ready
//   busy           : query in progress (COLLECT, VOTE, DONE)
//   result_valid   : one-cycle pulse with the classification
//   result_label   : majority label (held)
//   vote_count     : retained neighbours with label 1 (held)
//   nearest_dist   : distance of entry 0 at result time (held)
module knn_topk_vote #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned K          = 5,
    localparam int unsigned CW        = $clog2(K + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dist_valid,
    input  logic [DATA_WIDTH-1:0] distance_i,
    input  logic                  label_i,
    input  logic                  last_i,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  result_valid,
    output logic                  result_label,
    output logic [CW-1:0]         vote_count,
    output logic [DATA_WIDTH-1:0] nearest_dist
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StVote    = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    logic [1:0] state_q, state_d;

    logic [K-1:0]                 vld_q, vld_d;
    logic [K-1:0][DATA_WIDTH-1:0] dist_q, dist_d;
    logic [K-1:0]                 lbl_q, lbl_d;

    logic                  result_label_q, result_label_d;
    logic [CW-1:0]         vote_count_q, vote_count_d;
    logic [DATA_WIDTH-1:0] nearest_dist_q, nearest_dist_d;

    // Insertion working signals
    logic                         accept;
    logic [K-1:0]                 base_vld;
    logic [K-1:0]                 ge;
    logic [K-1:0]                 sh_vld;
    logic [K-1:0][DATA_WIDTH-1:0] sh_dist;
    logic [K-1:0]                 sh_lbl;
    logic                         prev_ge;

    // Vote working signals
    logic [CW-1:0] n_cnt;
    logic [CW-1:0] c_cnt;
    logic [CW:0]   c_x2;
    logic [CW:0]   n_x1;

    assign in_ready     = (state_q == StCollect);
    assign busy         = (state_q != StIdle);
    assign result_valid = (state_q == StDone);
    assign result_label = result_label_q;
    assign vote_count   = vote_count_q;
    assign nearest_dist = nearest_dist_q;

    // Next state
    always_comb begin
        state_d = state_q;
        if (start) begin
            // A sample arriving with start is taken, including its last flag.
            state_d = (dist_valid && last_i) ? StVote : StCollect;
        end else begin
            case (state_q)
                StIdle:    state_d = StIdle;
                StCollect: if (dist_valid && last_i) state_d = StVote;
                StVote:    state_d = StDone;
                StDone:    state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    // Sorted insertion. Valid entries always form a prefix, so the entries
    // with vld && dist <= distance_i are exactly entries 0..p-1.
    always_comb begin
        accept   = dist_valid && (start || (state_q == StCollect));
        base_vld = start ? '0 : vld_q;

        for (int i = 0; i < K; i++) begin
            ge[i] = base_vld[i] && (dist_q[i] <= distance_i);
        end

        // Packed-array shifts move entry i to i+1; works for K == 1 too.
        sh_vld  = base_vld << 1;
        sh_dist = dist_q << DATA_WIDTH;
        sh_lbl  = lbl_q << 1;

        vld_d   = base_vld;
        dist_d  = dist_q;
        lbl_d   = lbl_q;
        prev_ge = 1'b1;

        if (accept) begin
            for (int i = 0; i < K; i++) begin
                if (!ge[i]) begin
                    if (prev_ge) begin
                        vld_d[i]  = 1'b1;
                        dist_d[i] = distance_i;
                        lbl_d[i]  = label_i;
                    end else begin
                        vld_d[i]  = sh_vld[i];
                        dist_d[i] = sh_dist[i];
                        lbl_d[i]  = sh_lbl[i];
                    end
                end
                prev_ge = ge[i];
            end
        end
    end

    // Vote over the retained list
    always_comb begin
        n_cnt = '0;
        c_cnt = '0;
        for (int i = 0; i < K; i++) begin
            n_cnt = n_cnt + CW'(vld_q[i]);
            c_cnt = c_cnt + CW'(vld_q[i] & lbl_q[i]);
        end
        c_x2 = {c_cnt, 1'b0};
        n_x1 = {1'b0, n_cnt};

        result_label_d = result_label_q;
        vote_count_d   = vote_count_q;
        nearest_dist_d = nearest_dist_q;

        // A start during VOTE aborts the query, so the held result stays put.
        if ((state_q == StVote) && !start) begin
            vote_count_d   = c_cnt;
            nearest_dist_d = vld_q[0] ? dist_q[0] : '0;
            if (n_cnt == '0) begin
                result_label_d = 1'b0;
            end else if (c_x2 > n_x1) begin
                result_label_d = 1'b1;
            end else if (c_x2 < n_x1) begin
                result_label_d = 1'b0;
            end else begin
                result_label_d = lbl_q[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            vld_q          <= '0;
            dist_q         <= '0;
            lbl_q          <= '0;
            result_label_q <= 1'b0;
            vote_count_q   <= '0;
            nearest_dist_q <= '0;
        end else begin
            state_q        <= state_d;
            vld_q          <= vld_d;
            dist_q         <= dist_d;
            lbl_q          <= lbl_d;
            result_label_q <= result_label_d;
            vote_count_q   <= vote_count_d;
            nearest_dist_q <= nearest_dist_d;
        end
    end

endmodule
